// File: rtl/core_pkg.sv
// Shared core definitions for the fetch slice.
//   XLEN          datapath width
//   NOP_INSTR     instruction register value after reset (addi x0,x0,0)
//   fetch_state_t fetch FSM states
package core_pkg;
   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      VALID = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit, the control FSM and the instruction memory.
//   slave  : fetch unit view (takes requests/acks/redirects and memory data,
//            drives the memory address and the fetched-instruction outputs)
//   master : control FSM / memory side view
interface instr_fetch_unit_if;
   import core_pkg::*;

   logic            fetch_req;
   logic            instr_ack;
   logic            pc_load;
   logic [XLEN-1:0] pc_target;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic [XLEN-1:0] ir;
   logic [XLEN-1:0] ir_pc;
   logic [XLEN-1:0] pc;
   logic            instr_valid;
   logic            busy;
   logic            misalign_err;
   logic [XLEN-1:0] fetch_count;

   modport slave (
      input  fetch_req, instr_ack, pc_load, pc_target, imem_rdata,
      output imem_addr, ir, ir_pc, pc, instr_valid, busy, misalign_err, fetch_count
   );

   modport master (
      output fetch_req, instr_ack, pc_load, pc_target, imem_rdata,
      input  imem_addr, ir, ir_pc, pc, instr_valid, busy, misalign_err, fetch_count
   );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register.
//   clk, rst : clock, synchronous active-high reset (pc <= RESET_PC)
//   load     : redirect, pc <= target with the low two bits cleared
//   inc      : advance by one word, wrapping modulo IMEM_WORDS*4
//   target   : redirect address
//   pc       : current fetch address (always word aligned)
// Priority is rst > load > inc.
module fetch_pc_reg
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              IMEM_WORDS = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            inc,
   input  logic [XLEN-1:0] target,
   output logic [XLEN-1:0] pc
);
   localparam logic [XLEN-1:0] SPAN       = XLEN'(IMEM_WORDS * 4);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic [XLEN-1:0] pc_plus4;

   // A redirect may leave pc above the memory span; the increment still
   // folds it back into range.
   assign pc_plus4 = (pc + XLEN'(4)) % SPAN;

   always_ff @(posedge clk) begin
      if (rst)
         pc <= RESET_PC & ALIGN_MASK;
      else if (load)
         pc <= target & ALIGN_MASK;
      else if (inc)
         pc <= pc_plus4;
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side initiator: owns PC and IR, drives a 1-cycle registered
// instruction memory, holds the fetched instruction until acked, and
// accepts PC redirects that abort any in-flight fetch.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_unit_if.slave (requests, acks, redirects, memory
//              address/data, ir/ir_pc/pc, status flags, fetch counter)
module instr_fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              IMEM_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   instr_fetch_unit_if.slave bus
);
   fetch_state_t    state, state_nxt;
   logic            pc_inc;
   logic            ir_we;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] ir_q;
   logic [XLEN-1:0] ir_pc_q;
   logic [XLEN-1:0] cnt_q;
   logic            mis_q;

   // pc_load is honoured in every state; the PC register itself applies
   // reset ahead of it.
   fetch_pc_reg #(
      .RESET_PC   (RESET_PC),
      .IMEM_WORDS (IMEM_WORDS)
   ) u_pc (
      .clk    (clk),
      .rst    (rst),
      .load   (bus.pc_load),
      .inc    (pc_inc),
      .target (bus.pc_target),
      .pc     (pc_q)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Entering WAIT is the edge at which the memory samples pc, so the data
   // arriving in WAIT belongs to the current pc unless a redirect aborts it.
   always_comb begin
      state_nxt = state;
      pc_inc    = 1'b0;
      ir_we     = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.pc_load && bus.fetch_req) state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.pc_load) begin
               state_nxt = IDLE;
            end else begin
               ir_we     = 1'b1;
               pc_inc    = 1'b1;
               state_nxt = VALID;
            end
         end
         VALID: begin
            // A redirect alongside ack+req must not fetch the stale pc.
            if (bus.instr_ack)
               state_nxt = (bus.fetch_req && !bus.pc_load) ? WAIT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q    <= NOP_INSTR;
         ir_pc_q <= '0;
         cnt_q   <= '0;
         mis_q   <= 1'b0;
      end else begin
         mis_q <= bus.pc_load && (bus.pc_target[1:0] != 2'b00);
         if (ir_we) begin
            ir_q    <= bus.imem_rdata;
            ir_pc_q <= pc_q;
            cnt_q   <= cnt_q + XLEN'(1);
         end
      end
   end

   assign bus.imem_addr    = pc_q;
   assign bus.pc           = pc_q;
   assign bus.ir           = ir_q;
   assign bus.ir_pc        = ir_pc_q;
   assign bus.fetch_count  = cnt_q;
   assign bus.instr_valid  = (state == VALID);
   assign bus.busy         = (state == WAIT);
   assign bus.misalign_err = mis_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   import core_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus();

   // Instruction memory: registered read of the word at addr[9:2].
   logic [31:0] mem [0:255];
   always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[9:2]];

   instr_fetch_unit #(
      .RESET_PC   (RESET_PC),
      .IMEM_WORDS (256)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: a fetch is either in flight, or an instruction is
   // being held, or neither.
   logic [31:0] m_pc, m_ir, m_irpc, m_cnt;
   bit          m_inflight, m_hold, m_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clock();
      logic [31:0] tgt;
      tgt = bus.pc_target & ~32'd3;
      if (rst) begin
         m_pc = RESET_PC; m_ir = NOP_INSTR; m_irpc = 0; m_cnt = 0;
         m_inflight = 0; m_hold = 0; m_mis = 0;
         return;
      end
      m_mis = bus.pc_load && (bus.pc_target % 4 != 0);
      if (m_inflight) begin
         m_inflight = 0;
         if (bus.pc_load) m_pc = tgt;
         else begin
            m_ir   = mem[(m_pc % 1024) / 4];
            m_irpc = m_pc;
            m_pc   = (m_pc + 4) % 1024;
            m_cnt  = m_cnt + 1;
            m_hold = 1;
         end
      end else if (m_hold) begin
         if (bus.pc_load) m_pc = tgt;
         if (bus.instr_ack) begin
            m_hold = 0;
            if (bus.fetch_req && !bus.pc_load) m_inflight = 1;
         end
      end else begin
         if (bus.pc_load) m_pc = tgt;
         else if (bus.fetch_req) m_inflight = 1;
      end
   endtask

   // One clock: model follows the edge, outputs are compared 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
      chk("pc",          bus.pc,           m_pc);
      chk("imem_addr",   bus.imem_addr,    m_pc);
      chk("ir",          bus.ir,           m_ir);
      chk("ir_pc",       bus.ir_pc,        m_irpc);
      chk("fetch_count", bus.fetch_count,  m_cnt);
      chk("instr_valid", 32'(bus.instr_valid),  32'(m_hold));
      chk("busy",        32'(bus.busy),         32'(m_inflight));
      chk("misalign",    32'(bus.misalign_err), 32'(m_mis));
   endtask

   task automatic drive(input bit req, input bit ack, input bit ld, input logic [31:0] tgt);
      bus.fetch_req = req;
      bus.instr_ack = ack;
      bus.pc_load   = ld;
      bus.pc_target = tgt;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_pc"},    bus.pc,           RESET_PC);
      chk({tag, "_ir"},    bus.ir,           32'h0000_0013);
      chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
      chk({tag, "_busy"},  32'(bus.busy),         32'd0);
      chk({tag, "_count"}, bus.fetch_count,  32'd0);
   endtask

   initial begin
      logic [31:0] saved_ir, saved_cnt;
      int          seen;

      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      rst = 1'b1;
      drive(0, 0, 0, 32'h0);
      tick(); tick();
      chk_reset_state("reset");
      chk("reset_irpc", bus.ir_pc, 32'd0);
      rst = 1'b0;

      // 1: single fetches, latency of two clocks
      drive(1, 0, 0, 0); tick();
      chk("t1_busy", 32'(bus.busy), 32'd1);
      drive(0, 0, 0, 0); tick();
      chk("t1_valid", 32'(bus.instr_valid), 32'd1);
      chk("t1_ir",    bus.ir,    32'h0050_0093);
      chk("t1_irpc",  bus.ir_pc, 32'd0);
      chk("t1_pc",    bus.pc,    32'd4);
      drive(0, 1, 0, 0); tick();
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
      chk("t1_ir2",    bus.ir,          32'h00A0_0113);
      chk("t1_irpc2",  bus.ir_pc,       32'd4);
      chk("t1_count2", bus.fetch_count, 32'd2);
      drive(0, 1, 0, 0); tick();

      // 2: streaming, one instruction every two clocks
      rst = 1'b1; drive(0, 0, 0, 0); tick(); rst = 1'b0;
      seen = 0;
      drive(1, 1, 0, 0);
      for (int c = 0; c < 16; c++) begin
         tick();
         if (bus.instr_valid) begin
            chk("t2_irpc", bus.ir_pc, 32'(seen * 4));
            seen++;
         end
      end
      chk("t2_n", 32'(seen), 32'd8);
      drive(0, 1, 0, 0); tick();

      // 3: redirect aborts an in-flight fetch
      drive(1, 0, 0, 0); tick();
      saved_ir = bus.ir; saved_cnt = bus.fetch_count;
      drive(0, 0, 1, 32'h40); tick();
      chk("t3_busy",  32'(bus.busy), 32'd0);
      chk("t3_ir",    bus.ir,          saved_ir);
      chk("t3_count", bus.fetch_count, saved_cnt);
      chk("t3_pc",    bus.pc,          32'h40);
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
      chk("t3_ir2",   bus.ir,    mem[16]);
      chk("t3_irpc",  bus.ir_pc, 32'h40);
      drive(0, 1, 0, 0); tick();

      // 4: misaligned redirect, wrap at top of memory
      drive(0, 0, 1, 32'h43); tick();
      chk("t4_pc",  bus.pc, 32'h40);
      chk("t4_mis", 32'(bus.misalign_err), 32'd1);
      drive(0, 0, 0, 0); tick();
      chk("t4_mis_off", 32'(bus.misalign_err), 32'd0);
      drive(0, 0, 1, 32'h3FC); tick();
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
      chk("t4_wrap",  bus.pc,    32'd0);
      chk("t4_irpc",  bus.ir_pc, 32'h3FC);
      chk("t4_ir",    bus.ir,    mem[255]);
      drive(0, 1, 0, 0); tick();

      // 5: reset in WAIT and in VALID
      drive(1, 0, 0, 0); tick();
      rst = 1'b1; drive(0, 0, 0, 0); tick(); rst = 1'b0;
      chk_reset_state("t5_wait");
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk_reset_state("t5_valid");

      // 6: held instruction survives redirects until acked
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
      saved_ir = bus.ir;
      for (int c = 0; c < 5; c++) begin
         drive(0, 0, 1, 32'h80); tick();
         chk("t6_ir_stable", bus.ir, saved_ir);
         chk("t6_valid",     32'(bus.instr_valid), 32'd1);
      end
      drive(1, 1, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
      chk("t6_ir",   bus.ir,    mem[32]);
      chk("t6_irpc", bus.ir_pc, 32'h80);

      // redirect + ack + req together: drop to IDLE at the new target
      drive(1, 1, 1, 32'h100); tick();
      chk("t7_busy",  32'(bus.busy),        32'd0);
      chk("t7_valid", 32'(bus.instr_valid), 32'd0);
      chk("t7_pc",    bus.pc,               32'h100);

      // random traffic against the model
      drive(0, 0, 0, 0); tick();
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 99) < 2);
         drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023)));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
